// File: rtl/conv_psum_accumulator_pkg.sv
// Shared widths and saturation helpers for the partial-sum accumulator.
package conv_psum_accumulator_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ACC_WIDTH_DEF  = 32;
  localparam int CH_WIDTH       = 8;

  // Saturation limits for a signed activation of the given width.
  localparam int SAT_MAX_DEF = (1 << (DATA_WIDTH_DEF - 1)) - 1;
  localparam int SAT_MIN_DEF = -(1 << (DATA_WIDTH_DEF - 1));

  function automatic longint sat_max(input int dw);
    return (longint'(1) << (dw - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int dw);
    return -(longint'(1) << (dw - 1));
  endfunction

endpackage

// File: rtl/conv_psum_accumulator_fifo.sv
// Small synchronous FIFO holding {channel, activation} results for writeback.
// The head entry is presented combinationally and holds while not popped.
module psum_out_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  // Occupancy bookkeeping.
  always_comb begin
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Storage: one register per entry so reset clears the visible head.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_q[gi] <= '0;
        end else if (do_push && (wr_ptr_q == AW'(gi))) begin
          mem_q[gi] <= push_data_i;
        end
      end
    end
  endgenerate

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/conv_psum_accumulator.sv
// Per-output-channel partial-sum accumulator with bias, ReLU, rounding shift,
// saturation and a valid/ready output FIFO toward writeback.
module conv_psum_accumulator
  import conv_psum_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int NUM_OUT_CH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*DATA_WIDTH-1:0] in_result,
  input  logic [CH_WIDTH-1:0]     in_ch,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic                    cfg_bias_we,
  input  logic [CH_WIDTH-1:0]     cfg_bias_addr,
  input  logic [ACC_WIDTH-1:0]    cfg_bias_data,
  input  logic [4:0]              cfg_shift,
  input  logic                    cfg_relu_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [CH_WIDTH-1:0]     out_ch,
  output logic                    busy,
  output logic                    err_ch
);

  localparam int IDX_W = (NUM_OUT_CH > 1) ? $clog2(NUM_OUT_CH) : 1;
  // Two guard bits: one for the bias add, one so the rounding offset
  // cannot wrap even when the biased sum sits at the extreme.
  localparam int VW    = ACC_WIDTH + 2;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic signed [VW-1:0] SAT_HI = VW'(sat_max(DATA_WIDTH));
  localparam logic signed [VW-1:0] SAT_LO = VW'(sat_min(DATA_WIDTH));

  logic signed [ACC_WIDTH-1:0] acc_q  [NUM_OUT_CH];
  logic signed [ACC_WIDTH-1:0] bias_q [NUM_OUT_CH];

  logic                        accept, ch_ok, acc_we, bias_we_ok;
  logic [IDX_W-1:0]            in_idx, p1_idx;
  logic signed [ACC_WIDTH-1:0] in_sext, acc_base, new_sum;

  logic                        p1_v_q;
  logic signed [ACC_WIDTH-1:0] p1_sum_q;
  logic [CH_WIDTH-1:0]         p1_ch_q;

  logic                        p2_v_q;
  logic [DATA_WIDTH-1:0]       p2_data_q, p2_data_d;
  logic [CH_WIDTH-1:0]         p2_ch_q;

  logic signed [ACC_WIDTH-1:0] bias_sel;
  logic signed [VW-1:0]        v_sum, v_relu, round_add, v_round, v_shift, v_sat;

  logic                        err_q;
  logic [CNT_W-1:0]            fifo_count;

  assign accept     = in_valid && in_ready;
  assign ch_ok      = (int'(in_ch) < NUM_OUT_CH);
  assign acc_we     = accept && ch_ok;
  assign bias_we_ok = cfg_bias_we && (int'(cfg_bias_addr) < NUM_OUT_CH);
  assign in_idx     = in_ch[IDX_W-1:0];
  assign p1_idx     = p1_ch_q[IDX_W-1:0];

  // Read-modify-write of the addressed accumulator; in_first restarts from zero.
  always_comb begin
    in_sext  = ACC_WIDTH'($signed(in_result));
    acc_base = in_first ? '0 : acc_q[in_idx];
    new_sum  = acc_base + in_sext;
  end

  // Accumulator bank and bias table, one register per channel.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT_CH; gi++) begin : g_ch
      // Accumulator for channel gi; overflow wraps.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_q[gi] <= '0;
        end else if (acc_we && (in_idx == IDX_W'(gi))) begin
          acc_q[gi] <= new_sum;
        end
      end

      // Bias entry for channel gi.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bias_q[gi] <= '0;
        end else if (bias_we_ok && (cfg_bias_addr == CH_WIDTH'(gi))) begin
          bias_q[gi] <= cfg_bias_data;
        end
      end
    end
  endgenerate

  // P1: capture the completed sum when the last input channel arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_v_q   <= 1'b0;
      p1_sum_q <= '0;
      p1_ch_q  <= '0;
    end else begin
      p1_v_q <= acc_we && in_last;
      if (acc_we && in_last) begin
        p1_sum_q <= new_sum;
        p1_ch_q  <= in_ch;
      end
    end
  end

  // Requantise: bias (with same-cycle write bypass), ReLU, round-half-up shift, saturate.
  always_comb begin
    bias_sel  = (bias_we_ok && (cfg_bias_addr == p1_ch_q)) ? cfg_bias_data : bias_q[p1_idx];
    v_sum     = VW'(p1_sum_q) + VW'(bias_sel);
    v_relu    = (cfg_relu_en && (v_sum < 0)) ? '0 : v_sum;
    round_add = (cfg_shift == 5'd0) ? '0 : (VW'(1) << (cfg_shift - 5'd1));
    v_round   = v_relu + round_add;
    v_shift   = v_round >>> cfg_shift;
    if (v_shift > SAT_HI) begin
      v_sat = SAT_HI;
    end else if (v_shift < SAT_LO) begin
      v_sat = SAT_LO;
    end else begin
      v_sat = v_shift;
    end
    p2_data_d = v_sat[DATA_WIDTH-1:0];
  end

  // P2: register the saturated activation for the FIFO push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p2_v_q    <= 1'b0;
      p2_data_q <= '0;
      p2_ch_q   <= '0;
    end else begin
      p2_v_q <= p1_v_q;
      if (p1_v_q) begin
        p2_data_q <= p2_data_d;
        p2_ch_q   <= p1_ch_q;
      end
    end
  end

  // Sticky out-of-range channel flag; the offending beat is still consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept && !ch_ok) begin
      err_q <= 1'b1;
    end
  end

  psum_out_fifo #(
    .WIDTH (DATA_WIDTH + CH_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (p2_v_q),
    .push_data_i ({p2_ch_q, p2_data_q}),
    .pop_i       (out_ready),
    .valid_o     (out_valid),
    .head_o      ({out_ch, out_data}),
    .count_o     (fifo_count)
  );

  // Reserve FIFO space for everything in flight so an emit can never be dropped.
  assign in_ready = (OCC_W'(fifo_count) + OCC_W'(p1_v_q) + OCC_W'(p2_v_q)) < OCC_W'(FIFO_DEPTH);
  assign busy     = p1_v_q || p2_v_q || (fifo_count != '0);
  assign err_ch   = err_q;

endmodule

// File: tb/tb_conv_psum_accumulator.sv
// Directed bench for conv_psum_accumulator with hand-computed expected outputs.
module tb_conv_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_first, in_last;
  logic [15:0] in_result;
  logic [7:0]  in_ch;
  logic        cfg_bias_we;
  logic [7:0]  cfg_bias_addr;
  logic [31:0] cfg_bias_data;
  logic [4:0]  cfg_shift;
  logic        cfg_relu_en;
  logic        out_valid, out_ready;
  logic [7:0]  out_data, out_ch;
  logic        busy, err_ch;

  int n_cmp = 0;
  int n_bad = 0;
  int got_data[$];
  int got_ch[$];

  always #5 clk = ~clk;

  conv_psum_accumulator #(
    .DATA_WIDTH (8),
    .ACC_WIDTH  (32),
    .NUM_OUT_CH (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_result     (in_result),
    .in_ch         (in_ch),
    .in_first      (in_first),
    .in_last       (in_last),
    .cfg_bias_we   (cfg_bias_we),
    .cfg_bias_addr (cfg_bias_addr),
    .cfg_bias_data (cfg_bias_data),
    .cfg_shift     (cfg_shift),
    .cfg_relu_en   (cfg_relu_en),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_ch        (out_ch),
    .busy          (busy),
    .err_ch        (err_ch)
  );

  // Output monitor: record every handshake, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_data.push_back(int'($signed(out_data)));
      got_ch.push_back(int'(out_ch));
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Present one beat and hold it until accepted; returns 1 time unit after the accept edge.
  task automatic send(input int ch, input int val, input bit first, input bit last);
    int n = 0;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_ch     = 8'(ch);
    in_result = 16'(val);
    in_first  = first;
    in_last   = last;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic bias_wr(input int addr, input int data);
    @(posedge clk); #1;
    cfg_bias_we   = 1'b1;
    cfg_bias_addr = 8'(addr);
    cfg_bias_data = 32'(data);
    @(posedge clk); #1;
    cfg_bias_we = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int d, input int ch);
    int n = 0;
    while (got_data.size() == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (got_data.size() == 0) begin
      chk({tag, " timeout"}, 0, 1);
    end else begin
      chk({tag, " data"}, got_data.pop_front(), d);
      chk({tag, " ch"}, got_ch.pop_front(), ch);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int held;
    int bp_ch[6];
    bp_ch = '{0, 2, 3, 4, 5, 6};

    rst_n = 1'b0;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_result = '0; in_ch = '0;
    cfg_bias_we = 1'b0; cfg_bias_addr = '0; cfg_bias_data = '0;
    cfg_shift = '0; cfg_relu_en = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_ch", out_ch, 0);
    chk("reset err_ch", err_ch, 0);
    chk("reset busy", busy, 0);
    #20 rst_n = 1'b1;

    // Basic three-beat accumulation with latency check.
    send(2, 10, 1, 0);
    send(2, 20, 0, 0);
    send(2, 30, 0, 1);
    @(negedge clk);
    chk("basic c+1 out_valid", out_valid, 0);
    chk("basic busy", busy, 1);
    @(negedge clk);
    chk("basic c+2 out_valid", out_valid, 0);
    @(negedge clk);
    chk("basic c+3 out_valid", out_valid, 1);
    expect_out("basic", 60, 2);

    // Bias, rounding shift and high saturation.
    bias_wr(1, -7);
    @(posedge clk); #1 cfg_shift = 5'd1;
    send(1, 12, 1, 1);
    expect_out("bias+round pos", 3, 1);
    send(1, -12, 1, 1);
    expect_out("bias+round neg", -9, 1);
    @(posedge clk); #1 cfg_shift = 5'd0;
    send(1, 300, 1, 0);
    send(1, 300, 0, 1);
    expect_out("sat high", 127, 1);

    // ReLU on and off, then low saturation.
    @(posedge clk); #1 cfg_relu_en = 1'b1;
    send(0, -50, 1, 0);
    send(0, 20, 0, 1);
    expect_out("relu on", 0, 0);
    @(posedge clk); #1 cfg_relu_en = 1'b0;
    send(0, -50, 1, 0);
    send(0, 20, 0, 1);
    expect_out("relu off", -30, 0);
    send(0, -200, 1, 1);
    expect_out("sat low", -128, 0);

    // Interleaved channels.
    send(0, 5, 1, 0);
    send(3, 7, 1, 0);
    send(0, 1, 0, 1);
    send(3, 2, 0, 1);
    expect_out("interleave 1st", 6, 0);
    expect_out("interleave 2nd", 9, 3);

    // Backpressure: four single-beat channels fill the FIFO, the fifth stalls.
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(bp_ch[i], 11 * (i + 1), 1, 1);
    @(posedge clk); #1;
    in_valid = 1'b1; in_ch = 8'(bp_ch[4]); in_result = 16'(55);
    in_first = 1'b1; in_last = 1'b1;
    repeat (6) @(negedge clk);
    chk("bp in_ready low", in_ready, 0);
    chk("bp out_valid", out_valid, 1);
    chk("bp head data", int'($signed(out_data)), 11);
    held = int'(out_data);
    repeat (3) @(negedge clk);
    chk("bp head held", int'(out_data), held);
    chk("bp head ch", out_ch, 0);
    chk("bp nothing popped", got_data.size(), 0);
    @(posedge clk); #1 out_ready = 1'b1;
    send(bp_ch[4], 55, 1, 1);
    send(bp_ch[5], 66, 1, 1);
    for (int i = 0; i < 6; i++) expect_out($sformatf("bp out %0d", i), 11 * (i + 1), bp_ch[i]);

    // Out-of-range channel: consumed, flagged, nothing emitted.
    send(9, 5, 1, 1);
    repeat (6) @(negedge clk);
    chk("err_ch set", err_ch, 1);
    chk("err no output", got_data.size(), 0);
    chk("err not busy", busy, 0);

    // Reset in the middle of an accumulation.
    send(0, 100, 1, 0);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst out_data", out_data, 0);
    chk("midrst out_ch", out_ch, 0);
    chk("midrst err_ch", err_ch, 0);
    #3 rst_n = 1'b1;
    got_data.delete();
    got_ch.delete();
    send(0, 4, 0, 1);
    expect_out("post-reset acc", 4, 0);

    repeat (8) @(negedge clk);
    chk("no extra outputs", got_data.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
